piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, with framing strobes.
- Acts as the transmit end for the team's serial-in shift-register chains; its sout drives their serial input directly.
- Supports back-to-back words with no idle bit and a hold (enable) for flow control.

Parameters:
- WIDTH, 4, word width in bits; must be 2 or greater.
- MSB_FIRST, 1, 1 sends din[WIDTH-1] first; 0 sends din[0] first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high; clears all state immediately.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle (combinational).
- en  input  1  shift enable; 0 freezes an in-progress word.
- sout  output  1  serial data bit (registered).
- sout_valid  output  1  sout carries a valid bit (registered).
- sout_last  output  1  sout is the final bit of the word (registered).
- busy  output  1  a word is in progress (state SHIFT).

Behaviour:
- Reset (clr=1, any time, including mid-word):
  - state=IDLE, shift register=0, bit counter=0.
  - sout=0, sout_valid=0, sout_last=0, busy=0.
  - The partial word is discarded. No resumption after clr deasserts.
- States: IDLE, SHIFT. A 2-state FSM plus a down-counter cnt, width clog2(WIDTH).
- din_ready = (state==IDLE) OR (state==SHIFT AND cnt==0 AND en). Combinational, not registered.
- Accept: din_valid AND din_ready at a rising edge.
- IDLE:
  - On accept, load din into the shift register and set cnt=WIDTH-1.
  - At that same edge, drive the first bit onto sout, set sout_valid=1, sout_last=0, and go to SHIFT.
  - First-bit latency is 1 cycle after the accept edge.
  - en is ignored in IDLE; acceptance does not depend on en.
  - With no accept: sout=0, sout_valid=0.
- SHIFT, en=1, cnt>0:
  - At the edge, present the next bit and decrement cnt.
  - Set sout_last=1 when the new cnt==0.
- SHIFT, en=1, cnt==0 (last bit currently on sout):
  - If din_valid: accept the new word at this edge. Its first bit appears next cycle with sout_valid still 1, giving zero gap. Reload cnt=WIDTH-1, stay in SHIFT.
  - Otherwise: go to IDLE with sout=0, sout_valid=0, sout_last=0.
- SHIFT, en=0:
  - sout, sout_valid, sout_last, cnt and the shift register all hold.
  - din_ready=0.
  - The bit currently on sout stays valid and is repeated; the downstream receiver must gate its capture with en.
- din_valid while din_ready=0 is ignored. din is sampled only on an accept edge, so the upstream may change it freely otherwise.
- busy=1 exactly while state==SHIFT.
- Every valid word produces exactly WIDTH bits, and sout_last is high on exactly one of them.
- Bit order follows MSB_FIRST. The shift direction is fixed at elaboration.

Test Plan:
1. Reset then single word: WIDTH=4, MSB_FIRST=1, hold en=1. Pulse din=4'b1011 with din_valid for 1 cycle.
   -> sout = 1,0,1,1 on cycles 1-4 after accept; sout_valid=1 on those 4 cycles only; sout_last=1 only on cycle 4; busy=1 on cycles 1-4; din_ready=0 on cycles 1-3.
2. Back-to-back: offer 4'b1011, then hold din=4'b0110 with din_valid=1.
   -> 8 contiguous valid bits 1,0,1,1,0,1,1,0 with no gap; sout_last on bits 4 and 8; second word accepted at the bit-4 edge.
3. Hold: load 4'b1001 and drop en for 3 cycles after bit 2.
   -> sout holds 0 with sout_valid=1 for 3 extra cycles; remaining bits 0,1 follow after en returns; the total count of en=1 valid cycles is 4.
4. Reset mid-word: assert clr asynchronously (between edges) during bit 2 of 4'b1111.
   -> sout, sout_valid, sout_last and busy go to 0 immediately, without waiting for a clock edge; din_ready=1 after clr deasserts; a new word 4'b0001 then transmits cleanly as 0,0,0,1.
5. LSB-first: MSB_FIRST=0, din=4'b1101.
   -> sout = 1,0,1,1, i.e. din[0] first.
6. Ignored offer: assert din_valid with din=4'b0000 while bits 1-3 of 4'b1010 are in flight.
   -> no effect on the stream (1,0,1,0); that offer is accepted only at the last-bit edge if din_valid is still high.

Source files
------------

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Purpose  : Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word
//             over a valid/ready handshake and shifts it out one bit per
//             enabled clock. A framing strobe marks the final bit of each word.
//             Back-to-back words are sent with no idle bit between them.
//  Ports    : clk        - system clock, rising edge
//             clr        - asynchronous active-high reset
//             din        - parallel word to transmit
//             din_valid  - din holds a word to send
//             din_ready  - word can be accepted this cycle (combinational)
//             en         - shift enable; 0 freezes an in-progress word
//             sout       - serial data bit (registered)
//             sout_valid - sout carries a valid bit (registered)
//             sout_last  - sout is the final bit of the word (registered)
//             busy       - a word is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0]    c_st_idle  = 1'b0;
  localparam logic [0:0]    c_st_shift = 1'b1;
  localparam logic [CW-1:0] c_cnt_max  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             w_accept;
  logic             w_sout;
  logic [WIDTH-1:0] w_shifted;

  // The bit on sout is always the leading end of the shift register, so the
  // register itself is the output flop; clearing it parks sout at 0 when idle.
  if (MSB_FIRST) begin : g_msb_first
    assign w_sout    = sreg_q[WIDTH-1];
    assign w_shifted = {sreg_q[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_sout    = sreg_q[0];
    assign w_shifted = {1'b0, sreg_q[WIDTH-1:1]};
  end

  // Ready in IDLE, or on the last bit of a word when that bit is about to
  // retire; the latter gives the zero-gap back-to-back handoff.
  assign din_ready = (state_q == c_st_idle) ||
                     ((state_q == c_st_shift) && (cnt_q == '0) && en);
  assign w_accept  = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    valid_d = valid_q;
    last_d  = last_q;

    case (state_q)
      c_st_idle: begin
        if (w_accept) begin
          state_d = c_st_shift;
          cnt_d   = c_cnt_max;
          sreg_d  = din;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end else begin
          sreg_d  = '0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end

      c_st_shift: begin
        // en=0 falls through with every register holding its value.
        if (en) begin
          if (cnt_q != '0) begin
            sreg_d = w_shifted;
            cnt_d  = cnt_q - c_cnt_one;
            last_d = (cnt_q == c_cnt_one);
          end else if (w_accept) begin
            cnt_d   = c_cnt_max;
            sreg_d  = din;
            valid_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            state_d = c_st_idle;
            sreg_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = c_st_idle;
        cnt_d   = '0;
        sreg_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= c_st_idle;
      cnt_q   <= '0;
      sreg_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign sout       = w_sout;
  assign sout_valid = valid_q;
  assign sout_last  = last_q;
  assign busy       = (state_q == c_st_shift);

endmodule
`default_nettype wire
